// File: rtl/uart_hex_tx.sv
// uart_hex_tx
//   Serial result reporter. A single-cycle start latches a 64-bit result and
//   its size select. The active nibbles are sent most significant first as
//   upper-case ASCII hex characters, each in its own 8N1 UART frame. Frames
//   are sent back to back, with no idle gap between them.
//
//   Optional feature: define UART_HEX_CRLF_EN to append CR (0x0D) and LF (0x0A)
//   after the hex digits.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   BAUD      line rate; clocks per bit CPB = CLK_HZ / BAUD (must be >= 2)
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     launch request, sampled only while idle
//   data      64-bit result, latched on an accepted start
//   size_sel  digit count: 00->4, 01->8, 10->12, 11->16 (low nibbles of data)
//   busy      high from the accepted-start edge until the transfer ends
//   done      one-cycle pulse when the last stop bit completes
//   uart_txd  serial output, idles high
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | line high, waiting for start
// S_START   | start bit (low) of the current character
// S_DATA    | 8 data bits, LSB first
// S_STOP    | stop bit (high); then next char or finish
module uart_hex_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data,
    input  logic [1:0]  size_sel,
    output logic        busy,
    output logic        done,
    output logic        uart_txd
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
`ifdef UART_HEX_CRLF_EN
    localparam int EXTRA_CHARS = 2;
`else
    localparam int EXTRA_CHARS = 0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [4:0]         chars_q, chars_d;
    logic [63:0]        shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               baud_end;
    logic [3:0]         nib;
    logic [7:0]         cur_char;

    assign baud_end = (baud_q == CNT_W'(CPB - 1));

    // The shift register is left-aligned at load time, so the current digit is
    // always the top nibble. chars_q counts the characters still to send,
    // including the current one. This count selects the CR/LF tail when it is
    // enabled.
    always_comb begin
        nib = shift_q[63:60];
        if (nib < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nib};
        end else begin
            cur_char = 8'h37 + {4'h0, nib};
        end
`ifdef UART_HEX_CRLF_EN
        if (chars_q == 5'd2) begin
            cur_char = 8'h0D;
        end else if (chars_q == 5'd1) begin
            cur_char = 8'h0A;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        chars_d = chars_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (start) begin
                    // Left-align the active digits: shift by 16*(3-size_sel) bits.
                    shift_d = data << {2'd3 - size_sel, 4'b0000};
                    chars_d = (({3'b000, size_sel} + 5'd1) << 2) + 5'(EXTRA_CHARS);
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = cur_char[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_char[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (chars_q == 5'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        chars_d = chars_q - 5'd1;
                        shift_d = shift_q << 4;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            chars_q <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            chars_q <= chars_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/uart_hex_tx.md
# uart_hex_tx

Serial result reporter that sits downstream of the top-level result register: it takes a latched 64-bit result and its operand-size select, converts the active nibbles to ASCII hex characters (most significant first), and transmits them as 8N1 UART frames on the board TX pin. A single-cycle `start` launches a transfer, `busy` covers it, and `done` pulses when the last stop bit has completed. It replaces the fixed-message path for numeric output so the result register can be shown at 16/32/48/64-bit width.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate. Internal `CPB = CLK_HZ / BAUD` (integer division, 868 at defaults). `CPB` must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  launch request; sampled only when `busy` = 0.
- `data`  in  64  result value; latched on accepted `start`.
- `size_sel`  in  2  digit count select: 00→4, 01→8, 10→12, 11→16 hex digits (low nibbles of `data`).
- `busy`  out  1  high from the accepted-start edge until the transfer ends.
- `done`  out  1  one-cycle pulse at transfer end.
- `uart_txd`  out  1  serial line; idles high.

## Operation
- Reset values: `uart_txd`=1, `busy`=0, `done`=0. State IDLE; all counters 0.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: `uart_txd`=1. When `start`=1, latch `data` into a shift register, load char count `N = 4*(size_sel+1)`, go to START_BIT, and set `busy`=1.
- Char generation: current nibble = top active nibble of the shift register. Values 0–9 map to 0x30–0x39; A–F map to 0x41–0x46 (upper case). After each char, shift left by 4.
- START_BIT: `uart_txd`=0 for CPB cycles → DATA_BITS.
- DATA_BITS: 8 bits, LSB first, CPB cycles each; bit index 0..7 → STOP_BIT.
- STOP_BIT: `uart_txd`=1 for CPB cycles. Then, if chars remain, go to START_BIT (no idle gap). Otherwise go to IDLE, with `busy`=0 and `done`=1 for one cycle.
- `start` while `busy`=1: ignored, no queuing. `data`/`size_sel` changes while busy: no effect.
- `start` in the same cycle `done` pulses (`busy` still 1): ignored. It is accepted from the next cycle on.
- `rst` wins over `start`. `rst` mid-frame: next edge `uart_txd`=1, `busy`=0, no `done` pulse. A partial character on the line is allowed.

## Timing
- Accepted start at edge E0 (IDLE, `start`=1): `uart_txd` goes 0 and `busy` goes 1 at E0. Zero-cycle output latency; outputs are registered.
- Bit k of the transfer (k = 0 .. 10·C−1, C = total chars) drives `uart_txd` on edges E0+k·CPB through E0+(k+1)·CPB−1.
- End at edge E0+10·C·CPB: `busy`→0, `done`→1. At the following edge `done`→0.
- Minimum start-to-start spacing: 10·C·CPB + 1 cycles.
- Baud counter: counts 0..CPB−1 and resets on every bit boundary. Frame timing has no cumulative drift.

## Configuration
- `UART_HEX_CRLF_EN` defined: two extra chars, 0x0D then 0x0A, follow the hex digits, so C = N+2.
- Not defined: C = N, and the line returns to idle directly after the last digit.

## Test plan
All scenarios use `CLK_HZ`=10, `BAUD`=1, giving CPB=10. The macro is undefined unless stated.
- Reset: hold `rst` 3 cycles with `start`=1 → `uart_txd`=1, `busy`=0, `done`=0 throughout; no frame starts.
- `data`=64'h0000_0000_0000_BEEF, `size_sel`=00, `start` pulse at E0 → line decodes to 0x42,0x45,0x45,0x46. `busy`=1 for exactly 400 cycles, `done` pulses at E0+400, each start bit falls on E0+100·i.
- `data`=64'h0123_4567_89AB_CDEF, `size_sel`=11 → 16 chars "0123456789ABCDEF" with digit mapping checked. `done` at E0+1600. Repeat with `size_sel`=10 → "456789ABCDEF", `done` at E0+1200.
- `start` re-asserted at E0+50 and at the `done` cycle → ignored, single transfer. `start` at `done`+1 → new transfer begins at that edge.
- `rst` at E0+137 during the second char → `uart_txd`=1 and `busy`=0 next edge, no `done`. A fresh start then transmits correctly.
- With `UART_HEX_CRLF_EN`, `data`=16'h00A5, `size_sel`=00 → "00A5" then 0x0D, 0x0A; `done` at E0+600.
